// File: rtl/fp_mul_result_buffer.sv
// fp_mul_result_buffer: captures single-precision multiplier products,
// classifies each one (normal/subnormal, zero, infinity, NaN), and buffers
// them in a first-word-fall-through FIFO with a valid/ready output.
// Maintains sticky exception flags for the downstream FP datapath.
// Compile-time option: define FP_CLASS_CNT_EN to add saturating 16-bit
// per-class event counters (cnt_total, cnt_nan, cnt_inf, cnt_zero).
module fp_mul_result_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic [1:0]            out_class,
   input  logic                  flag_clear,
   output logic                  flag_nan,
   output logic                  flag_inf,
   output logic                  flag_zero
`ifdef FP_CLASS_CNT_EN
   ,
   output logic [15:0]           cnt_total,
   output logic [15:0]           cnt_nan,
   output logic [15:0]           cnt_inf,
   output logic [15:0]           cnt_zero
`endif
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      CLS_NORM = 2'b00,
      CLS_ZERO = 2'b01,
      CLS_INF  = 2'b10,
      CLS_NAN  = 2'b11
   } fp_class_e;

   logic [DATA_WIDTH-1:0] mem_data  [DEPTH];
   fp_class_e             mem_class [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   fp_class_e             in_class;
   logic                  push;
   logic                  pop;

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out       = out_valid ? mem_data[rd_ptr] : '0;
   assign out_class = out_valid ? mem_class[rd_ptr] : CLS_NORM;

   // Classify the incoming product from its exponent and fraction fields.
   always_comb begin
      in_class = CLS_NORM;
      if (in[30:23] == 8'hFF) begin
         in_class = (in[22:0] != '0) ? CLS_NAN : CLS_INF;
      end else if (in[30:23] == 8'h00 && in[22:0] == '0) begin
         in_class = CLS_ZERO;
      end
   end

   // Store pushed word and its class at the write pointer.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_data[wr_ptr]  <= in;
         mem_class[wr_ptr] <= in_class;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky class flags; a coinciding push keeps its own flag set through a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_nan  <= 1'b0;
         flag_inf  <= 1'b0;
         flag_zero <= 1'b0;
      end else if (flag_clear) begin
         flag_nan  <= push && (in_class == CLS_NAN);
         flag_inf  <= push && (in_class == CLS_INF);
         flag_zero <= push && (in_class == CLS_ZERO);
      end else if (push) begin
         if (in_class == CLS_NAN)  flag_nan  <= 1'b1;
         if (in_class == CLS_INF)  flag_inf  <= 1'b1;
         if (in_class == CLS_ZERO) flag_zero <= 1'b1;
      end
   end

`ifdef FP_CLASS_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Saturating event counters; a push coinciding with clear loads 1 instead of 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_total <= '0;
         cnt_nan   <= '0;
         cnt_inf   <= '0;
         cnt_zero  <= '0;
      end else if (flag_clear) begin
         cnt_total <= push ? 16'd1 : '0;
         cnt_nan   <= (push && in_class == CLS_NAN)  ? 16'd1 : '0;
         cnt_inf   <= (push && in_class == CLS_INF)  ? 16'd1 : '0;
         cnt_zero  <= (push && in_class == CLS_ZERO) ? 16'd1 : '0;
      end else if (push) begin
         cnt_total <= sat_inc(cnt_total);
         if (in_class == CLS_NAN)  cnt_nan  <= sat_inc(cnt_nan);
         if (in_class == CLS_INF)  cnt_inf  <= sat_inc(cnt_inf);
         if (in_class == CLS_ZERO) cnt_zero <= sat_inc(cnt_zero);
      end
   end
`endif

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed self-checking bench for fp_mul_result_buffer (DEPTH=4).
// Counter checks are included when FP_CLASS_CNT_EN is defined.
module tb_fp_mul_result_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic [1:0]  out_class;
   logic        flag_clear;
   logic        flag_nan;
   logic        flag_inf;
   logic        flag_zero;
`ifdef FP_CLASS_CNT_EN
   logic [15:0] cnt_total, cnt_nan, cnt_inf, cnt_zero;
`endif

   int errors = 0;
   int checks = 0;

   fp_mul_result_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in         (in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .out_class  (out_class),
      .flag_clear (flag_clear),
      .flag_nan   (flag_nan),
      .flag_inf   (flag_inf),
      .flag_zero  (flag_zero)
`ifdef FP_CLASS_CNT_EN
      ,
      .cnt_total  (cnt_total),
      .cnt_nan    (cnt_nan),
      .cnt_inf    (cnt_inf),
      .cnt_zero   (cnt_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic n, input logic i, input logic z);
      chk({tag, "_nan"},  {31'd0, flag_nan},  {31'd0, n});
      chk({tag, "_inf"},  {31'd0, flag_inf},  {31'd0, i});
      chk({tag, "_zero"}, {31'd0, flag_zero}, {31'd0, z});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in = '0; out_ready = 1'b0; flag_clear = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out",       out,                32'd0);
      chk("rst_out_class", {30'd0, out_class}, 32'd0);
      chk_flags("rst", 1'b0, 1'b0, 1'b0);

      // push then reset: entry discarded
      in_valid = 1'b1; in = 32'h3F800000;
      step();
      chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_out",       out,                32'h3F800000);
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_out",       out,                32'd0);
      chk("rst2_in_ready",  {31'd0, in_ready},  32'd1);
      chk_flags("rst2", 1'b0, 1'b0, 1'b0);

      // push coinciding with reset is lost
      rst = 1'b1; in_valid = 1'b1; in = 32'h7F800000;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("rstpush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstpush_flag_inf",  {31'd0, flag_inf},  32'd0);

      // fill to full with out_ready low
      in_valid = 1'b1; in = 32'h40000000; step();
      in = 32'h7F800000; step();
      in = 32'h00000000; step();
      chk("fill3_in_ready", {31'd0, in_ready}, 32'd1);
      in = 32'h7FC00000; step();
      chk("fill4_in_ready", {31'd0, in_ready}, 32'd0);
      in = 32'h11111111; step();
      in_valid = 1'b0;
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_head",     out,               32'h40000000);
      chk_flags("fill", 1'b1, 1'b1, 1'b1);

      // drain in order
      out_ready = 1'b1;
      chk("d0_out", out, 32'h40000000); chk("d0_cls", {30'd0, out_class}, 32'd0);
      step();
      chk("d1_in_ready", {31'd0, in_ready}, 32'd1);
      chk("d1_out", out, 32'h7F800000); chk("d1_cls", {30'd0, out_class}, 32'd2);
      step();
      chk("d2_out", out, 32'h00000000); chk("d2_cls", {30'd0, out_class}, 32'd1);
      step();
      chk("d3_out", out, 32'h7FC00000); chk("d3_cls", {30'd0, out_class}, 32'd3);
      step();
      chk("d4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("d4_out",       out,                32'd0);
      chk("d4_out_class", {30'd0, out_class}, 32'd0);

      // streaming with wrap-around, occupancy stays at one
      in_valid = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in = 32'(i);
         step();
         chk("wrap_out",       out,                32'(i));
         chk("wrap_out_valid", {31'd0, out_valid}, 32'd1);
         chk("wrap_in_ready",  {31'd0, in_ready},  32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("wrap_empty", {31'd0, out_valid}, 32'd0);

      // push and pop together while full: only the pop happens
      out_ready = 1'b0; in_valid = 1'b1;
      in = 32'h3F800001; step();
      in = 32'h3F800002; step();
      in = 32'h3F800003; step();
      in = 32'h3F800004; step();
      in = 32'hEEEEEEEE; out_ready = 1'b1;
      step();
      chk("fullpp_in_ready", {31'd0, in_ready}, 32'd1);
      chk("fullpp_head",     out,               32'h3F800002);
      step();
      in_valid = 1'b0;
      chk("fullpp2_head", out, 32'h3F800003);
      step();
      chk("fullpp3_head", out, 32'h3F800004);
      step();
      chk("fullpp4_head", out, 32'hEEEEEEEE);
      step();
      chk("fullpp_empty", {31'd0, out_valid}, 32'd0);

      // push of negative zero coinciding with clear
      in_valid = 1'b1; in = 32'h80000000; flag_clear = 1'b1;
      step();
      in_valid = 1'b0; flag_clear = 1'b0;
      chk_flags("prio", 1'b0, 1'b0, 1'b1);
      chk("prio_cls", {30'd0, out_class}, 32'd1);
      step();
      flag_clear = 1'b1; step(); flag_clear = 1'b0;
      chk_flags("clr", 1'b0, 1'b0, 1'b0);
`ifdef FP_CLASS_CNT_EN
      chk("clr_cnt_total", {16'd0, cnt_total}, 32'd0);
`endif

      // subnormal classifies as normal
      in_valid = 1'b1; in = 32'h00000001;
      step();
      in_valid = 1'b0;
      chk("sub_out", out, 32'h00000001);
      chk("sub_cls", {30'd0, out_class}, 32'd0);
      chk_flags("sub", 1'b0, 1'b0, 1'b0);
`ifdef FP_CLASS_CNT_EN
      chk("sub_cnt_total", {16'd0, cnt_total}, 32'd1);
      chk("sub_cnt_zero",  {16'd0, cnt_zero},  32'd0);

      // counter saturation
      step();
      in_valid = 1'b1; in = 32'h7FC00001;
      for (int i = 0; i < 70000; i++) step();
      in_valid = 1'b0;
      step();
      chk("sat_cnt_nan",   {16'd0, cnt_nan},   32'h0000FFFF);
      chk("sat_cnt_total", {16'd0, cnt_total}, 32'h0000FFFF);
`endif
      step();

      // infinity push coinciding with clear
      in_valid = 1'b1; in = 32'h7F800000; flag_clear = 1'b1;
      step();
      in_valid = 1'b0; flag_clear = 1'b0;
      chk_flags("clrinf", 1'b0, 1'b1, 1'b0);
      chk("clrinf_cls", {30'd0, out_class}, 32'd2);
`ifdef FP_CLASS_CNT_EN
      chk("clrinf_cnt_total", {16'd0, cnt_total}, 32'd1);
      chk("clrinf_cnt_inf",   {16'd0, cnt_inf},   32'd1);
      chk("clrinf_cnt_nan",   {16'd0, cnt_nan},   32'd0);
      chk("clrinf_cnt_zero",  {16'd0, cnt_zero},  32'd0);
`endif
      step();
      chk("final_empty", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_mul_result_buffer.md
# fp_mul_result_buffer

- Sits directly downstream of the combinational single-precision multiplier and captures its 32-bit IEEE-754 products.
- Classifies each accepted product, buffers it in a small first-word-fall-through FIFO, and hands it on over a valid/ready handshake.
- Maintains sticky exception flags and, optionally, per-class event counters for the rest of the FP datapath and for debug.

## Interface
Parameters:
- DATA_WIDTH, 32, product word width; classification fields are fixed at sign [31], exponent [30:23], fraction [22:0].
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product on `in` is valid this cycle.
- in_ready  output  1  buffer can accept; equals "not full"; no combinational dependence on out_ready.
- in  input  DATA_WIDTH  product word from the multiplier.
- out_valid  output  1  buffer is non-empty.
- out_ready  input  1  consumer accepts head entry.
- out  output  DATA_WIDTH  head entry data; forced to 0 when empty.
- out_class  output  2  class of head entry: 00 normal/subnormal, 01 zero, 10 infinity, 11 NaN; 00 when empty.
- flag_clear  input  1  clears sticky flags (and counters when compiled in).
- flag_nan, flag_inf, flag_zero  output  1 each  sticky "class seen since last clear".
- cnt_total, cnt_nan, cnt_inf, cnt_zero  output  16 each  event counters; present only with FP_CLASS_CNT_EN.

## Operation
Push and pop:
- Push occurs when in_valid && in_ready.
- Pop occurs when out_valid && out_ready.
- Pop when empty is ignored.
- With in_ready low, in_valid is ignored and the word is not stored.

Classification is computed from `in` at push and stored alongside the data:
- exp==0xFF, frac!=0 → NaN.
- exp==0xFF, frac==0 → inf.
- exp==0x00, frac==0 → zero (either sign).
- Anything else → normal, including exp==0, frac!=0.

FIFO storage:
- Circular array of DEPTH entries, each {class, data}.
- Write and read pointers of log2(DEPTH) bits wrap naturally.
- Occupancy count is log2(DEPTH)+1 bits, range 0..DEPTH.

FIFO boundary rules:
- Simultaneous push and pop at 0 < count < DEPTH: count unchanged, both pointers advance.
- Simultaneous push and pop when full: only the pop happens, since in_ready=0.
- Simultaneous push and pop when empty: only the push happens.
- Pointers wrap from DEPTH-1 to 0 with no gap or bubble.

Sticky flags:
- A push of class X sets flag_X.
- flag_clear clears all three flags.
- If a push and flag_clear occur in the same cycle, set wins for the pushed class; all other flags clear.

## Timing
- Reset values: in_ready=1, out_valid=0, out=0, out_class=00, all flags=0, all counters=0, pointers=0, count=0.
- A reset asserted mid-operation discards all buffered entries at that edge. Any push or pop presented in the same cycle is lost.
- Latency: a word pushed at edge N appears on out/out_class with out_valid=1 in the cycle after edge N.
- That holds even when the FIFO was empty: there is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained while not full.
- Flags update at the push edge and are visible in the following cycle.
- in_ready deasserts in the cycle after the push that fills the FIFO.
- in_ready reasserts in the cycle after the first pop from full.

## Configuration
FP_CLASS_CNT_EN.

When defined:
- The four 16-bit counter ports exist.
- cnt_total increments on every push; cnt_nan, cnt_inf and cnt_zero increment on a push of the matching class.
- Each counter saturates at 0xFFFF.
- flag_clear zeroes all counters. If a push coincides with flag_clear, the matching counters load 1 instead of 0.

When undefined:
- The counter ports and registers are absent.
- Flag and FIFO behaviour is identical.

## Test plan
- Reset check: push 0x3F800000 then assert rst → next cycle out_valid=0, out=0, in_ready=1, all flags=0.
- Ordering and latency, DEPTH=4, out_ready=0:
  - Push 0x40000000, 0x7F800000, 0x00000000, 0x7FC00000 → in_ready=0 after the 4th push; a 5th word 0x11111111 is not stored.
  - Then out_ready=1 → out sequence in order with out_class 00, 10, 01, 11.
  - flag_inf=flag_zero=flag_nan=1.
- Wrap-around: stream 10 words 0x00000001..0x0000000A with in_valid=out_ready=1 continuously → all 10 emerge in order, one per cycle after the first, and count never exceeds 1.
- Flag priority: hold flags set, then push 0x80000000 with flag_clear=1 in the same cycle → flag_zero=1, flag_inf=0, flag_nan=0.
- Subnormal classification: push 0x00000001 → out_class=00 and no flag set.
- FP_CLASS_CNT_EN checks:
  - 70000 consecutive NaN pushes → cnt_nan=cnt_total=0xFFFF (saturated).
  - Then one push with flag_clear → cnt_total=1 and the class counter for that push's class =1.
  - Without the macro, the same flag and FIFO results hold.
